// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction handshake, downstream ALU op/a/b handshake,
// and the debug illegal-instruction count.
interface alu_issue_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1_data;
    logic [XLEN-1:0]  in_rs2_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_op;
    logic [XLEN-1:0]  out_a;
    logic [XLEN-1:0]  out_b;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_count;

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b, out_illegal, illegal_count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b, out_illegal, illegal_count
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes instruction + operands into ALU {op, a, b}
// and holds them in a registered 2-entry skid buffer.
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            illegal;
    } entry_t;

    state_t           state, state_nxt;
    entry_t           dec, head, tail;
    logic             acc, pop;
    logic             load_head_dec, load_head_tail, load_tail, clr_head, clr_tail;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  imm_i, imm_s, imm_u;

    assign funct3 = bus.in_instr[14:12];
    assign imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_s  = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
    assign imm_u  = {bus.in_instr[31:12], 12'b0};

    always_comb begin
        dec = '0;
        case (bus.in_instr[6:0])
            7'b0110011: begin
                dec.op = {bus.in_instr[30], funct3};
                dec.a  = bus.in_rs1_data;
                dec.b  = bus.in_rs2_data;
            end
            7'b0010011: begin
                // Only SRAI carries instr[30] into the op; shifts take the 5-bit shamt.
                dec.op = {(funct3 == 3'b101) && bus.in_instr[30], funct3};
                dec.a  = bus.in_rs1_data;
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec.b = {27'b0, bus.in_instr[24:20]};
                else
                    dec.b = imm_i;
            end
            7'b0110111: begin
                dec.b = imm_u;
            end
            7'b0010111: begin
                dec.a = bus.in_pc;
                dec.b = imm_u;
            end
            7'b0000011: begin
                dec.a = bus.in_rs1_data;
                dec.b = imm_i;
            end
            7'b0100011: begin
                dec.a = bus.in_rs1_data;
                dec.b = imm_s;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Ready depends only on the registered state, never on out_ready.
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign acc = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_head_dec  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        clr_head       = 1'b0;
        clr_tail       = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt     = ONE;
                    load_head_dec = 1'b1;
                end
            end
            ONE: begin
                if (acc && !pop) begin
                    state_nxt = FULL;
                    load_tail = 1'b1;
                end else if (acc && pop) begin
                    load_head_dec = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                    clr_head  = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_tail = 1'b1;
                    clr_tail       = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Head is cleared whenever it empties so idle outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head_dec)       head <= dec;
            else if (load_head_tail) head <= tail;
            else if (clr_head)       head <= '0;
            if (load_tail)           tail <= dec;
            else if (clr_tail)       tail <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (acc && dec.illegal && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign bus.out_op        = head.op;
    assign bus.out_a         = head.a;
    assign bus.out_b         = head.b;
    assign bus.out_illegal   = head.illegal;
    assign bus.illegal_count = cnt;
endmodule

// File: tb/tb_alu_issue.sv
// Directed scoreboard bench for alu_issue: decode values, skid-buffer backpressure,
// illegal counting/saturation and asynchronous reset.
module tb_alu_issue;
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(32), .CNT_W(16)) bus ();
    alu_issue_if #(.XLEN(32), .CNT_W(2))  sbus ();

    alu_issue #(.XLEN(32), .CNT_W(16)) dut     (.clk(clk), .reset(reset), .bus(bus));
    alu_issue #(.XLEN(32), .CNT_W(2))  dut_sat (.clk(clk), .reset(reset), .bus(sbus));

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic ill);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.ill = ill;
        return e;
    endfunction

    // Scoreboard monitor: the head entry must match the oldest expected entry every valid cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) begin
                n_cmp++;
                assert (sbq.size() != 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_out: observed op=%h a=%h b=%h, expected no entry",
                           bus.out_op, bus.out_a, bus.out_b);
                end
                if (sbq.size() != 0) begin
                    check("head_entry", {bus.out_op, bus.out_a, bus.out_b, bus.out_illegal}, sbq[0]);
                    if (bus.out_ready) void'(sbq.pop_front());
                end
            end else begin
                check("idle_zero", {bus.out_op, bus.out_a, bus.out_b, bus.out_illegal}, '0);
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input exp_t e, output int waited);
        bit done;
        done = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sbq.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        assert (done) else begin
            n_bad++;
            $error("FAIL accept_timeout: observed no accept, expected accept of %h", instr);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sbq.size() != 0 || bus.out_valid) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, 69'(sbq.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_pc = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        idle();
        sbus.in_valid = 1'b0;
        sbus.in_instr = '0;
        sbus.in_pc = '0;
        sbus.in_rs1_data = '0;
        sbus.in_rs2_data = '0;
        sbus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 69'(bus.in_ready), 69'(1));
        check("rst_out_valid", 69'(bus.out_valid), '0);
        check("rst_outputs", {bus.out_op, bus.out_a, bus.out_b, bus.out_illegal}, '0);
        check("rst_count", 69'(bus.illegal_count), '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ADD then SUB, first visible the cycle after accept
        send(32'h002081B3, 32'h0, 32'd5, 32'd3, mk(4'b0000, 32'd5, 32'd3, 1'b0), w);
        check("lat_valid", 69'(bus.out_valid), 69'(1));
        send(32'h402081B3, 32'h0, 32'd5, 32'd3, mk(4'b1000, 32'd5, 32'd3, 1'b0), w);
        idle();
        drain("drain_addsub");

        // Back-to-back issue with out_ready high: every send accepted without waiting
        send(32'hFFF00093, 32'h0, 32'd10, 32'd0, mk(4'b0000, 32'd10, 32'hFFFFFFFF, 1'b0), w);
        check("tp_addi", 69'(w), '0);
        send(32'h4040D093, 32'h0, 32'h80, 32'd0, mk(4'b1101, 32'h80, 32'd4, 1'b0), w);
        check("tp_srai", 69'(w), '0);
        send(32'h00409093, 32'h0, 32'd7, 32'd0, mk(4'b0001, 32'd7, 32'd4, 1'b0), w);
        check("tp_slli", 69'(w), '0);
        send(32'h12345037, 32'h0, 32'hDEAD, 32'hBEEF, mk(4'b0000, 32'h0, 32'h12345000, 1'b0), w);
        check("tp_lui", 69'(w), '0);
        send(32'h00001017, 32'h100, 32'hDEAD, 32'd0, mk(4'b0000, 32'h100, 32'h1000, 1'b0), w);
        check("tp_auipc", 69'(w), '0);
        send(32'hFE20AE23, 32'h0, 32'h2000, 32'd9, mk(4'b0000, 32'h2000, 32'hFFFFFFFC, 1'b0), w);
        check("tp_sw", 69'(w), '0);
        send(32'h00812083, 32'h0, 32'h40, 32'd0, mk(4'b0000, 32'h40, 32'd8, 1'b0), w);
        check("tp_lw", 69'(w), '0);
        send(32'h0020E1B3, 32'h0, 32'hF0, 32'h0F, mk(4'b0110, 32'hF0, 32'h0F, 1'b0), w);
        check("tp_or", 69'(w), '0);
        idle();
        drain("drain_imm");

        // Backpressure: two accepted, third stalls until out_ready returns
        bus.out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(4'b0000, 32'd1, 32'd2, 1'b0), w);
        check("bp_first", 69'(w), '0);
        send(32'h402081B3, 32'h0, 32'd3, 32'd4, mk(4'b1000, 32'd3, 32'd4, 1'b0), w);
        check("bp_second", 69'(w), '0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0020C1B3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 69'(bus.in_ready), '0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(32'h0020C1B3, 32'h0, 32'd5, 32'd6, mk(4'b0100, 32'd5, 32'd6, 1'b0), w);
        check("bp_third_waited", 69'(w), 69'(1));
        idle();
        drain("drain_bp");

        // Illegal opcode three times
        for (int k = 0; k < 3; k++)
            send(32'h0000007F, 32'h44, 32'h55, 32'h66, mk(4'b0000, 32'h0, 32'h0, 1'b1), w);
        idle();
        @(negedge clk);
        check("ill_count3", 69'(bus.illegal_count), 69'(3));
        drain("drain_ill");

        // Asynchronous reset while FULL
        bus.out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd7, 32'd8, mk(4'b0000, 32'd7, 32'd8, 1'b0), w);
        send(32'h002081B3, 32'h0, 32'd9, 32'd10, mk(4'b0000, 32'd9, 32'd10, 1'b0), w);
        idle();
        check("pre_rst_full", 69'(bus.in_ready), '0);
        #2;
        reset = 1'b1;
        #1;
        sbq.delete();
        check("arst_out_valid", 69'(bus.out_valid), '0);
        check("arst_in_ready", 69'(bus.in_ready), 69'(1));
        check("arst_count", 69'(bus.illegal_count), '0);
        check("arst_outputs", {bus.out_op, bus.out_a, bus.out_b, bus.out_illegal}, '0);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0020C1B3, 32'h0, 32'hAA, 32'h55, mk(4'b0100, 32'hAA, 32'h55, 1'b0), w);
        idle();
        drain("drain_post_rst");

        // Saturation on the 2-bit counter instance
        for (int k = 0; k < 5; k++) begin
            sbus.in_valid = 1'b1;
            sbus.in_instr = 32'h0000007F;
            @(posedge clk);
            #1;
            check("sat_count", 69'(sbus.illegal_count), 69'((k + 1 > 3) ? 3 : k + 1));
        end
        sbus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sat_hold", 69'(sbus.illegal_count), 69'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
